// File: rtl/clock_pkg.sv
// Shared types and limits for the digital clock timekeeping core.
// Exports: state_e (RUN/SET_HR/SET_MIN), FIELD_W, HR_MAX, MS_MAX.
package clock_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SET_HR  = 2'd1,
    ST_SET_MIN = 2'd2
  } state_e;

  localparam int FIELD_W = 8;

  localparam logic [FIELD_W-1:0] HR_MAX = 8'h23;
  localparam logic [FIELD_W-1:0] MS_MAX = 8'h59;

  // Next value of a 2-digit BCD field, wrapping to 00 after max.
  function automatic logic [FIELD_W-1:0] bcd_next(
    input logic [FIELD_W-1:0] q,
    input logic [FIELD_W-1:0] max
  );
    logic [FIELD_W-1:0] r;
    if (q == max)
      r = '0;
    else if (q[3:0] == 4'd9)
      r = {q[7:4] + 4'd1, 4'd0};
    else
      r = {q[7:4], q[3:0] + 4'd1};
    return r;
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit packed-BCD counter 00..MAX with clear, increment and wrap.
// Ports: clk, rst_n, i_inc, i_clr, o_q (BCD value), o_carry (inc at MAX).
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter logic [FIELD_W-1:0] MAX = MS_MAX
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_inc,
  input  logic               i_clr,
  output logic [FIELD_W-1:0] o_q,
  output logic               o_carry
);

  logic [FIELD_W-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_q <= '0;
    else if (i_clr)
      r_q <= '0;
    else if (i_inc)
      r_q <= bcd_next(r_q, MAX);
  end

  assign o_q     = r_q;
  assign o_carry = i_inc & (r_q == MAX);

endmodule

// File: rtl/time_keeper.sv
// HH:MM:SS BCD timekeeper with hour/minute set mode, auto-repeat and blink.
// Ports: clk, rst_n, tick_1hz/5hz, btn_mode/inc/inc_lvl -> hours, minutes, seconds, blanks, day_tick, set_active.
module time_keeper
  import clock_pkg::*;
#(
  parameter int BLINK_DIV  = 2,
  parameter int REPEAT_DLY = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick_1hz,
  input  logic               tick_5hz,
  input  logic               btn_mode,
  input  logic               btn_inc,
  input  logic               btn_inc_lvl,
  output logic [FIELD_W-1:0] hours,
  output logic [FIELD_W-1:0] minutes,
  output logic [FIELD_W-1:0] seconds,
  output logic               blank_hr,
  output logic               blank_min,
  output logic               day_tick,
  output logic               set_active
);

  localparam int RW = $clog2(REPEAT_DLY + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);

  state_e r_state;
  state_e w_state_nxt;

  logic [RW-1:0] r_rep_cnt;
  logic [RW-1:0] w_rep_cnt_nxt;
  logic [BW-1:0] r_blink_cnt;
  logic [BW-1:0] w_blink_cnt_nxt;
  logic          r_phase;
  logic          w_phase_nxt;

  logic r_blank_hr;
  logic r_blank_min;
  logic r_day_tick;
  logic r_set_active;

  logic w_set;
  logic w_rep_fire;
  logic w_inc_req;
  logic w_run_tick;
  logic w_sec_clr;
  logic w_sec_co;
  logic w_min_co;
  logic w_hr_co;
  logic w_min_inc;
  logic w_hr_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= ST_RUN;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (btn_mode) begin
      unique case (r_state)
        ST_RUN:     w_state_nxt = ST_SET_HR;
        ST_SET_HR:  w_state_nxt = ST_SET_MIN;
        ST_SET_MIN: w_state_nxt = ST_RUN;
        default:    w_state_nxt = ST_RUN;
      endcase
    end
  end

  assign w_set      = (r_state != ST_RUN);
  assign w_rep_fire = w_set & btn_inc_lvl & tick_5hz &
                      (r_rep_cnt == RW'(REPEAT_DLY));
  // A mode press takes priority; button and repeat merge into one step.
  assign w_inc_req  = w_set & ~btn_mode & (btn_inc | w_rep_fire);
  assign w_run_tick = (r_state == ST_RUN) & tick_1hz;
  assign w_sec_clr  = (r_state == ST_SET_MIN) & btn_mode;

  // Carries only exist in RUN; set-mode wraps stay within the field.
  assign w_min_inc = w_sec_co |
                     (w_inc_req & (r_state == ST_SET_MIN));
  assign w_hr_inc  = (w_sec_co & w_min_co) |
                     (w_inc_req & (r_state == ST_SET_HR));

  always_comb begin
    w_rep_cnt_nxt = r_rep_cnt;
    if (!w_set || !btn_inc_lvl || btn_mode)
      w_rep_cnt_nxt = '0;
    else if (tick_5hz && r_rep_cnt != RW'(REPEAT_DLY))
      w_rep_cnt_nxt = r_rep_cnt + RW'(1);
  end

  always_comb begin
    w_blink_cnt_nxt = r_blink_cnt;
    w_phase_nxt     = r_phase;
    if (!w_set || btn_mode || w_inc_req) begin
      w_blink_cnt_nxt = '0;
      w_phase_nxt     = 1'b0;
    end else if (tick_5hz) begin
      if (r_blink_cnt == BW'(BLINK_DIV - 1)) begin
        w_blink_cnt_nxt = '0;
        w_phase_nxt     = ~r_phase;
      end else begin
        w_blink_cnt_nxt = r_blink_cnt + BW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rep_cnt    <= '0;
      r_blink_cnt  <= '0;
      r_phase      <= 1'b0;
      r_blank_hr   <= 1'b0;
      r_blank_min  <= 1'b0;
      r_day_tick   <= 1'b0;
      r_set_active <= 1'b0;
    end else begin
      r_rep_cnt    <= w_rep_cnt_nxt;
      r_blink_cnt  <= w_blink_cnt_nxt;
      r_phase      <= w_phase_nxt;
      r_blank_hr   <= (w_state_nxt == ST_SET_HR) & w_phase_nxt;
      r_blank_min  <= (w_state_nxt == ST_SET_MIN) & w_phase_nxt;
      r_day_tick   <= w_sec_co & w_min_co & w_hr_co;
      r_set_active <= (w_state_nxt != ST_RUN);
    end
  end

  bcd_mod_counter #(.MAX(MS_MAX)) u_sec (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_run_tick),
    .i_clr   (w_sec_clr),
    .o_q     (seconds),
    .o_carry (w_sec_co)
  );

  bcd_mod_counter #(.MAX(MS_MAX)) u_min (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_min_inc),
    .i_clr   (1'b0),
    .o_q     (minutes),
    .o_carry (w_min_co)
  );

  bcd_mod_counter #(.MAX(HR_MAX)) u_hr (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_hr_inc),
    .i_clr   (1'b0),
    .o_q     (hours),
    .o_carry (w_hr_co)
  );

  assign blank_hr   = r_blank_hr;
  assign blank_min  = r_blank_min;
  assign day_tick   = r_day_tick;
  assign set_active = r_set_active;

endmodule

// File: tb/tb_time_keeper.sv
// Self-checking bench for time_keeper: vector table plus
// directed multi-cycle sequences.
module tb_time_keeper;

  logic       clk;
  logic       rst_n;
  logic       tick_1hz;
  logic       tick_5hz;
  logic       btn_mode;
  logic       btn_inc;
  logic       btn_inc_lvl;
  logic [7:0] hours;
  logic [7:0] minutes;
  logic [7:0] seconds;
  logic       blank_hr;
  logic       blank_min;
  logic       day_tick;
  logic       set_active;

  int checks   = 0;
  int failures = 0;

  time_keeper #(.BLINK_DIV(2), .REPEAT_DLY(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick_1hz    (tick_1hz),
    .tick_5hz    (tick_5hz),
    .btn_mode    (btn_mode),
    .btn_inc     (btn_inc),
    .btn_inc_lvl (btn_inc_lvl),
    .hours       (hours),
    .minutes     (minutes),
    .seconds     (seconds),
    .blank_hr    (blank_hr),
    .blank_min   (blank_min),
    .day_tick    (day_tick),
    .set_active  (set_active)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    logic       t1;
    logic       t5;
    logic       m;
    logic       i;
    logic [7:0] h;
    logic [7:0] mi;
    logic [7:0] s;
    logic       bh;
    logic       bm;
    logic       st;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t v(
    input logic t1, input logic t5,
    input logic m, input logic i,
    input logic [7:0] h, input logic [7:0] mi,
    input logic [7:0] s, input logic bh,
    input logic bm, input logic st
  );
    vec_t r;
    r.t1 = t1; r.t5 = t5; r.m = m; r.i = i;
    r.h = h; r.mi = mi; r.s = s;
    r.bh = bh; r.bm = bm; r.st = st;
    return r;
  endfunction

  function automatic logic [7:0] bcd(input int n);
    return 8'(((n / 10) << 4) | (n % 10));
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
               name, got, exp);
    end
  endtask

  task automatic chk_time(input string name,
                          input int h, input int m,
                          input int s);
    chk({name, ".hr"}, {24'd0, hours}, {24'd0, bcd(h)});
    chk({name, ".min"}, {24'd0, minutes}, {24'd0, bcd(m)});
    chk({name, ".sec"}, {24'd0, seconds}, {24'd0, bcd(s)});
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic step(input logic t1, input logic t5,
                      input logic m, input logic i);
    tick_1hz = t1;
    tick_5hz = t5;
    btn_mode = m;
    btn_inc  = i;
    @(posedge clk);
    @(negedge clk);
    tick_1hz = 1'b0;
    tick_5hz = 1'b0;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
  endtask

  task automatic do_reset();
    tick_1hz    = 1'b0;
    tick_5hz    = 1'b0;
    btn_mode    = 1'b0;
    btn_inc     = 1'b0;
    btn_inc_lvl = 1'b0;
    rst_n       = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic preload(input int h, input int m, input int s);
    do_reset();
    step(0, 0, 1, 0);
    repeat (h) step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    repeat (m) step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    repeat (s) step(1, 0, 0, 0);
  endtask

  initial begin
    logic day_seen;

    tbl[0]  = v(1,0,0,0, 8'h00,8'h00,8'h01, 0,0,0);
    tbl[1]  = v(0,0,0,1, 8'h00,8'h00,8'h01, 0,0,0);
    tbl[2]  = v(1,0,0,0, 8'h00,8'h00,8'h02, 0,0,0);
    tbl[3]  = v(0,0,1,1, 8'h00,8'h00,8'h02, 0,0,1);
    tbl[4]  = v(1,0,0,0, 8'h00,8'h00,8'h02, 0,0,1);
    tbl[5]  = v(0,0,0,1, 8'h01,8'h00,8'h02, 0,0,1);
    tbl[6]  = v(0,1,0,0, 8'h01,8'h00,8'h02, 0,0,1);
    tbl[7]  = v(0,1,0,0, 8'h01,8'h00,8'h02, 1,0,1);
    tbl[8]  = v(0,0,0,1, 8'h02,8'h00,8'h02, 0,0,1);
    tbl[9]  = v(0,1,0,0, 8'h02,8'h00,8'h02, 0,0,1);
    tbl[10] = v(0,1,0,0, 8'h02,8'h00,8'h02, 1,0,1);
    tbl[11] = v(0,0,1,0, 8'h02,8'h00,8'h02, 0,0,1);
    tbl[12] = v(0,1,0,0, 8'h02,8'h00,8'h02, 0,0,1);
    tbl[13] = v(0,1,0,0, 8'h02,8'h00,8'h02, 0,1,1);
    tbl[14] = v(1,0,0,0, 8'h02,8'h00,8'h02, 0,1,1);
    tbl[15] = v(0,0,0,1, 8'h02,8'h01,8'h02, 0,0,1);
    tbl[16] = v(0,0,1,0, 8'h02,8'h01,8'h00, 0,0,0);
    tbl[17] = v(1,0,0,0, 8'h02,8'h01,8'h01, 0,0,0);

    // Reset state
    do_reset();
    rst_n = 1'b0;
    #1;
    chk_time("reset", 0, 0, 0);
    chk("reset.bh", {31'd0, blank_hr}, 0);
    chk("reset.bm", {31'd0, blank_min}, 0);
    chk("reset.day", {31'd0, day_tick}, 0);
    chk("reset.set", {31'd0, set_active}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table
    for (int k = 0; k < 18; k++) begin
      step(tbl[k].t1, tbl[k].t5, tbl[k].m, tbl[k].i);
      chk($sformatf("vec%0d.hr", k), {24'd0, hours},
          {24'd0, tbl[k].h});
      chk($sformatf("vec%0d.min", k), {24'd0, minutes},
          {24'd0, tbl[k].mi});
      chk($sformatf("vec%0d.sec", k), {24'd0, seconds},
          {24'd0, tbl[k].s});
      chk($sformatf("vec%0d.bh", k), {31'd0, blank_hr},
          {31'd0, tbl[k].bh});
      chk($sformatf("vec%0d.bm", k), {31'd0, blank_min},
          {31'd0, tbl[k].bm});
      chk($sformatf("vec%0d.set", k), {31'd0, set_active},
          {31'd0, tbl[k].st});
      chk($sformatf("vec%0d.day", k), {31'd0, day_tick}, 0);
    end

    // 61 seconds from reset
    do_reset();
    day_seen = 1'b0;
    for (int k = 0; k < 61; k++) begin
      step(1, 0, 0, 0);
      day_seen = day_seen | day_tick;
    end
    chk_time("t61", 0, 1, 1);
    chk("t61.day", {31'd0, day_seen}, 0);

    // Day rollover
    preload(23, 59, 58);
    chk_time("pre", 23, 59, 58);
    step(1, 0, 0, 0);
    chk_time("roll1", 23, 59, 59);
    chk("roll1.day", {31'd0, day_tick}, 0);
    step(1, 0, 0, 0);
    chk_time("roll2", 0, 0, 0);
    chk("roll2.day", {31'd0, day_tick}, 1);
    step(0, 0, 0, 0);
    chk("roll3.day", {31'd0, day_tick}, 0);

    // Hour set and wrap
    do_reset();
    step(0, 0, 1, 0);
    chk("sethr.set", {31'd0, set_active}, 1);
    repeat (3) step(0, 0, 0, 1);
    chk("sethr.hr3", {24'd0, hours}, {24'd0, bcd(3)});
    preload(0, 37, 0);
    step(0, 0, 1, 0);
    repeat (23) step(0, 0, 0, 1);
    chk("hrwrap.23", {24'd0, hours}, {24'd0, bcd(23)});
    step(0, 0, 0, 1);
    chk_time("hrwrap", 0, 37, 0);
    chk("hrwrap.day", {31'd0, day_tick}, 0);

    // Frozen in SET_MIN, seconds cleared on exit
    preload(12, 34, 56);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    chk("frz.set", {31'd0, set_active}, 1);
    repeat (3) step(1, 0, 0, 0);
    chk_time("frz", 12, 34, 56);
    step(0, 0, 1, 0);
    chk_time("exit", 12, 34, 0);
    chk("exit.set", {31'd0, set_active}, 0);

    // Auto-repeat
    do_reset();
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    btn_inc_lvl = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step(0, 1, 0, 0);
      step(0, 0, 0, 0);
      if (k == 5)
        chk("rep5.min", {24'd0, minutes}, 0);
    end
    chk("rep10.min", {24'd0, minutes}, {24'd0, bcd(5)});
    step(0, 1, 0, 1);
    chk("rep_inc.min", {24'd0, minutes}, {24'd0, bcd(6)});
    btn_inc_lvl = 1'b0;
    step(0, 1, 0, 0);
    chk("rep_off.min", {24'd0, minutes}, {24'd0, bcd(6)});

    // Mode beats inc
    do_reset();
    step(0, 0, 1, 1);
    chk("mode_inc.hr", {24'd0, hours}, 0);
    chk("mode_inc.set", {31'd0, set_active}, 1);

    // Async reset in SET_MIN
    preload(12, 34, 56);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("pre_rst.bm", {31'd0, blank_min}, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk_time("arst", 0, 0, 0);
    chk("arst.set", {31'd0, set_active}, 0);
    chk("arst.bm", {31'd0, blank_min}, 0);
    chk("arst.bh", {31'd0, blank_hr}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 0, 0);
    chk_time("post_rst", 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
